// File: rtl/spi_reg_arbiter_pkg.sv
// Shared SPI controller register map and arbiter FSM encodings.
// Imported by the arbiter, its picker and anything else that talks to the register port.
package spi_reg_arbiter_pkg;

  localparam logic [7:0]  ADDR_SPMODE = 8'h00;
  localparam logic [7:0]  ADDR_SPIE   = 8'h04;
  localparam logic [7:0]  ADDR_SPIM   = 8'h08;
  localparam logic [7:0]  ADDR_SPCOM  = 8'h0C;
  localparam logic [7:0]  ADDR_SPITF  = 8'h10;
  localparam logic [7:0]  ADDR_SPIRF  = 8'h14;

  localparam logic [31:0] SPMODE_DEF  = 32'h0000_100F;

  // One access walks IDLE -> SETUP -> STROBE -> SETTLE -> DONE -> IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/spi_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: the first valid requester strictly after
// the pointer wins, wrapping NREQ-1 -> 0. Reusable by any shared-port block.
module spi_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    found
);
  localparam int IW = $clog2(NREQ);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Round-robin arbiter sharing the SPI controller register port between NREQ
// requesters; each grant runs setup / 1-cycle strobe / settle / done.
module spi_reg_arbiter
  import spi_reg_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 8,
  parameter int DW   = 32
) (
  input  logic              S_SYSCLK,
  input  logic              S_RESET,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [NREQ-1:0]   REQ_WRITE,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_WDATA,
  input  logic [NREQ*4-1:0] REQ_WSTRB,
  output logic [NREQ-1:0]   REQ_DONE,
  output logic [DW-1:0]     REQ_RDATA,
  output logic [AW-1:0]     S_AWADDR,
  output logic [DW-1:0]     S_WDATA,
  output logic [3:0]        S_WSTRB,
  output logic              S_REG_WEN,
  output logic [AW-1:0]     S_ARADDR,
  input  logic [DW-1:0]     S_RDATA,
  output logic              S_REG_RDEN,
  output logic              BUSY
);
  localparam int IW = $clog2(NREQ);

  logic [AW-1:0] req_addr_a  [NREQ];
  logic [DW-1:0] req_wdata_a [NREQ];
  logic [3:0]    req_wstrb_a [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_addr_a[gi]  = REQ_ADDR[gi*AW +: AW];
    assign req_wdata_a[gi] = REQ_WDATA[gi*DW +: DW];
    assign req_wstrb_a[gi] = REQ_WSTRB[gi*4 +: 4];
  end

  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;

  state_e          state_q,  state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] grant_q,  grant_d;
  logic            wr_q,     wr_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [DW-1:0]   wdata_q,  wdata_d;
  logic [3:0]      wstrb_q,  wstrb_d;
  logic            wen_q,    wen_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic            rden_q,   rden_d;
  logic [NREQ-1:0] done_q,   done_d;
  logic [DW-1:0]   rdata_q,  rdata_d;
  logic            busy_q,   busy_d;

  spi_rr_pick #(.NREQ(NREQ)) u_pick (
    .valid (REQ_VALID),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    wr_d     = wr_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wen_d    = wen_q;
    araddr_d = araddr_q;
    rden_d   = rden_q;
    done_d   = done_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d  = pick_grant;
          rr_ptr_d = pick_idx;
          wr_d     = REQ_WRITE[pick_idx];
          // Only the side of the port being used moves; the other keeps its last values.
          if (REQ_WRITE[pick_idx]) begin
            awaddr_d = req_addr_a[pick_idx];
            wdata_d  = req_wdata_a[pick_idx];
            wstrb_d  = req_wstrb_a[pick_idx];
          end else begin
            araddr_d = req_addr_a[pick_idx];
          end
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wen_d   = wr_q;
        rden_d  = ~wr_q;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        wen_d   = 1'b0;
        rden_d  = 1'b0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!wr_q) rdata_d = S_RDATA;
        done_d  = grant_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
    if (S_RESET) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= IW'(NREQ - 1);
      grant_q  <= '0;
      wr_q     <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wen_q    <= 1'b0;
      araddr_q <= '0;
      rden_q   <= 1'b0;
      done_q   <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      wr_q     <= wr_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wen_q    <= wen_d;
      araddr_q <= araddr_d;
      rden_q   <= rden_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
    end
  end

  assign REQ_DONE   = done_q;
  assign REQ_RDATA  = rdata_q;
  assign S_AWADDR   = awaddr_q;
  assign S_WDATA    = wdata_q;
  assign S_WSTRB    = wstrb_q;
  assign S_REG_WEN  = wen_q;
  assign S_ARADDR   = araddr_q;
  assign S_REG_RDEN = rden_q;
  assign BUSY       = busy_q;

endmodule
